// File: rtl/data_memory_if.sv
// Request/response channel between the load/store unit (requester) and the data memory.
interface memory_port;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data_wr;
    logic [31:0] data_rd;

    modport memory (
        input  valid,
        input  we,
        input  addr,
        input  width,
        input  data_wr,
        output data_rd
    );

    modport requester (
        output valid,
        output we,
        output addr,
        output width,
        output data_wr,
        input  data_rd
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed little-endian data RAM with registered reads, byte-masked writes,
// a power-on clear sequencer and sticky misaligned-access fault capture.
module data_memory #(
    parameter int DEPTH_WORDS    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    memory_port.memory  mem,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fault_addr,
    input  logic        fault_clr
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_idx;
    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      rd_data_p1;

    logic             ready;
    logic             aligned;
    logic             req_ok;
    logic             new_fault;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_en;
    logic [31:0]      wr_lanes;

    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] ofs);
        case (width)
            W_BYTE:  return 1'b1;
            W_HALF:  return ~ofs[0];
            W_WORD:  return (ofs == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] ofs);
        case (width)
            W_BYTE:  return 4'b0001 << ofs;
            W_HALF:  return ofs[1] ? 4'b1100 : 4'b0011;
            W_WORD:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the payload so every enabled lane finds its byte at the lane position.
    function automatic logic [31:0] place_lanes(input logic [1:0] width, input logic [31:0] data);
        case (width)
            W_BYTE:  return {4{data[7:0]}};
            W_HALF:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extract_lanes(input logic [1:0] width, input logic [1:0] ofs,
                                                  input logic [31:0] word);
        case (width)
            W_BYTE:  return {24'd0, word[{ofs, 3'b000} +: 8]};
            W_HALF:  return ofs[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            default: return word;
        endcase
    endfunction

    assign ready       = (state == S_READY);
    assign busy        = ~ready;
    assign word_idx    = mem.addr[IDX_W+1:2];
    assign aligned     = is_aligned(mem.width, mem.addr[1:0]);
    assign req_ok      = ready & mem.valid & aligned;
    assign new_fault   = ready & mem.valid & ~aligned;
    assign lane_en     = lane_mask(mem.width, mem.addr[1:0]);
    assign wr_lanes    = place_lanes(mem.width, mem.data_wr);
    assign mem.data_rd = rd_data_p1;

    // Clear sequencer: one word per cycle, then hand over to request service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_idx <= '0;
        end else if (state == S_CLEAR) begin
            clr_idx <= clr_idx + IDX_ONE;
            if (clr_idx == LAST_IDX) begin
                state <= S_READY;
            end
        end
    end

    // Array write port, shared between the clear sequencer and accepted stores.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem_q[clr_idx] <= '0;
        end else if (req_ok && mem.we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // p1: registered load data, held until the next accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (req_ok && !mem.we) begin
            rd_data_p1 <= extract_lanes(mem.width, mem.addr[1:0], mem_q[word_idx]);
        end
    end

    // A fresh fault on the same edge as fault_clr takes priority over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (new_fault && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_addr <= mem.addr;
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory against a byte-array reference model, plus directed literal checks.
module tb_data_memory;
    localparam int DEPTH  = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;
    logic        fault_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    memory_port mp();

    data_memory #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mp),
        .busy       (busy),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;

    // Reference model: flat byte array, countdown of remaining clear cycles.
    logic [7:0]  m_bytes [NBYTES];
    int          clear_left;
    logic [31:0] e_rd;
    logic        e_fault;
    logic [31:0] e_faddr;

    function automatic bit m_aligned(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd0) return 1'b1;
        if (w == 2'd1) return (a[0] == 1'b0);
        if (w == 2'd2) return (a[1:0] == 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] v;
        int base;
        v = 32'd0;
        base = int'(a % NBYTES);
        for (int i = 0; i < (1 << w); i++) v = v | (32'(m_bytes[base + i]) << (8 * i));
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left <= DEPTH;
            e_rd       <= 32'd0;
            e_fault    <= 1'b0;
            e_faddr    <= 32'd0;
            for (int i = 0; i < NBYTES; i++) m_bytes[i] <= 8'h00;
        end else begin
            if (clear_left > 0) begin
                clear_left <= clear_left - 1;
            end else if (mp.valid && m_aligned(mp.width, mp.addr)) begin
                if (mp.we) begin
                    for (int i = 0; i < (1 << mp.width); i++)
                        m_bytes[int'(mp.addr % NBYTES) + i] <= mp.data_wr[8*i +: 8];
                end else begin
                    e_rd <= m_read(mp.addr, mp.width);
                end
            end
            if (clear_left == 0 && mp.valid && !m_aligned(mp.width, mp.addr) && (!e_fault || fault_clr)) begin
                e_fault <= 1'b1;
                e_faddr <= mp.addr;
            end else if (fault_clr) begin
                e_fault <= 1'b0;
                e_faddr <= 32'd0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(clear_left != 0));
            chk("data_rd", mp.data_rd, e_rd);
            chk("fault", 32'(fault), 32'(e_fault));
            chk("fault_addr", fault_addr, e_faddr);
        end
    end

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [1:0] w, input logic [31:0] d);
        mp.valid   = v;
        mp.we      = we;
        mp.addr    = a;
        mp.width   = w;
        mp.data_wr = d;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 2'd2, 32'd0);
            tick();
            chk(name, mp.data_rd, 32'h0000_0000);
        end
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] exp_b [4];
        exp_b[0] = 32'h0000_00EF;
        exp_b[1] = 32'h0000_00BE;
        exp_b[2] = 32'h0000_00AD;
        exp_b[3] = 32'h0000_00DE;

        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_data_rd", mp.data_rd, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_fault_addr", fault_addr, 32'd0);
        wait_ready(n);
        chk("clear_cycles", 32'(n), 32'd16);
        read_all_zero("clear_read");

        drive(1'b1, 1'b1, 32'h8, 2'd2, 32'hDEAD_BEEF);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(8 + i), 2'd0, 32'd0);
            tick();
            chk("byte_read", mp.data_rd, exp_b[i]);
        end

        drive(1'b1, 1'b1, 32'h4, 2'd2, 32'h1122_3344);
        tick();
        drive(1'b1, 1'b1, 32'h6, 2'd1, 32'h0000_AAAA);
        tick();
        drive(1'b1, 1'b0, 32'h4, 2'd2, 32'd0);
        tick();
        chk("half_merge", mp.data_rd, 32'hAAAA_3344);

        drive(1'b1, 1'b1, 32'h2, 2'd2, 32'h5555_5555);
        tick();
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_addr_set", fault_addr, 32'h2);
        chk("fault_rd_hold", mp.data_rd, 32'hAAAA_3344);
        drive(1'b1, 1'b0, 32'h0, 2'd2, 32'd0);
        tick();
        chk("fault_no_write", mp.data_rd, 32'h0000_0000);
        drive(1'b1, 1'b1, 32'h5, 2'd1, 32'h0000_7777);
        tick();
        chk("fault_addr_sticky", fault_addr, 32'h2);
        fault_clr = 1'b1;
        drive(1'b1, 1'b0, 32'h11, 2'd2, 32'd0);
        tick();
        chk("clr_new_fault_wins", fault_addr, 32'h11);
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        tick();
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault), 32'd0);
        chk("fault_addr_cleared", fault_addr, 32'd0);

        drive(1'b1, 1'b1, 32'h0, 2'd3, 32'h1234_5678);
        tick();
        chk("bad_width_fault", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        tick();
        fault_clr = 1'b0;

        drive(1'b1, 1'b1, 32'h40, 2'd2, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 1'b0, 32'h0, 2'd2, 32'd0);
        tick();
        chk("alias_wrap", mp.data_rd, 32'hCAFE_F00D);

        for (int i = 0; i < 400; i++) begin
            fault_clr = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
                  2'($urandom_range(0, 3)), $urandom);
            tick();
        end
        fault_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 2'd2, $urandom | 32'h1);
            tick();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h2, 2'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) tick();
        chk("busy_mid_clear", 32'(busy), 32'd1);
        chk("busy_req_no_fault", 32'(fault), 32'd0);
        drive(1'b1, 1'b0, 32'h8, 2'd2, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        chk("restart_cycles", 32'(n), 32'd16);
        chk("busy_req_rd_hold", mp.data_rd, 32'd0);
        chk("busy_req_fault_hold", 32'(fault), 32'd0);
        read_all_zero("reclear_read");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
